// File: rtl/rvfi_mem_pkg.sv
// rvfi_mem_pkg: shared shadow-entry type (sized for data up to 64 bits), byte-merge helper and txn counter width
package rvfi_mem_pkg;
  localparam int TXN_CNT_W = 16;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;
  localparam int MAX_TAG_W = 64;
  typedef struct packed {
    logic                  vld;
    logic [MAX_TAG_W-1:0]  tag;
    logic [MAX_DATA_W-1:0] data;
  } shadow_entry_t;
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_d,
    input logic [MAX_DATA_W-1:0] new_d,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] r;
    for (int i = 0; i < MAX_STRB_W; i++) r[8*i+:8] = strb[i] ? new_d[8*i+:8] : old_d[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/rvfi_mem_shadow.sv
// rvfi_mem_shadow: round-robin tag store (clock, resetn, tag/wdata/wstrb/rand_rdata in, done = completing edge, rdata = hit data or rand_rdata)
module rvfi_mem_shadow
  import rvfi_mem_pkg::*;
#(
  parameter int TAG_W  = 30,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [TAG_W-1:0]    tag,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rand_rdata,
  input  logic                done,
  output logic [DATA_W-1:0]   rdata
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int STRB_W = DATA_W / 8;
  shadow_entry_t ent [DEPTH];
  logic [IDX_W-1:0] alloc_ptr, hit_idx, slot;
  logic hit;
  logic [MAX_TAG_W-1:0] tag_x;
  logic [MAX_DATA_W-1:0] rd_x, wd_x, merged;
  logic [MAX_STRB_W-1:0] strb_x;
  always_comb begin
    tag_x = '0;
    tag_x[TAG_W-1:0] = tag;
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent[i].vld && ent[i].tag == tag_x) begin
        hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
    rd_x = '0;
    rd_x[DATA_W-1:0] = rand_rdata;
    rd_x = hit ? ent[hit_idx].data : rd_x;
    wd_x = '0;
    wd_x[DATA_W-1:0] = wdata;
    strb_x = '0;
    strb_x[STRB_W-1:0] = wstrb;
    merged = merge_bytes(rd_x, wd_x, strb_x);
    slot = hit ? hit_idx : alloc_ptr;
  end
  assign rdata = rd_x[DATA_W-1:0];
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      alloc_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (done) begin
      ent[slot] <= '{vld: 1'b1, tag: tag_x, data: merged};
      alloc_ptr <= hit ? alloc_ptr : (alloc_ptr == IDX_W'(DEPTH - 1) ? '0 : alloc_ptr + 1'b1);
    end
endmodule

// File: rtl/rvfi_mem_responder.sv
// rvfi_mem_responder: bounded-stall memory responder with optional shadow memory, sticky protocol checker (proto_err) and txn_cnt
module rvfi_mem_responder
  import rvfi_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 3,
  parameter int DEPTH      = 4,
  parameter int CONSISTENT = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 mem_valid,
  input  logic                 mem_instr,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W/8-1:0]  mem_wstrb,
  output logic                 mem_ready,
  output logic [DATA_W-1:0]    mem_rdata,
  input  logic                 rand_ready,
  input  logic [DATA_W-1:0]    rand_rdata,
  output logic                 proto_err,
  output logic [TXN_CNT_W-1:0] txn_cnt
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W = STRB_W > 1 ? $clog2(STRB_W) : 0;
  localparam int WC_W = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  logic [WC_W-1:0] wait_cnt;
  logic stall, done, pend_vld, pend_instr;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;
  logic [STRB_W-1:0] pend_wstrb;
  assign mem_ready = resetn && mem_valid && (rand_ready || wait_cnt == WC_W'(MAX_WAIT));
  assign done = mem_valid && mem_ready;
  assign stall = mem_valid && !mem_ready;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      wait_cnt <= '0;
      pend_vld <= 1'b0;
      pend_instr <= 1'b0;
      pend_addr <= '0;
      pend_wdata <= '0;
      pend_wstrb <= '0;
      proto_err <= 1'b0;
      txn_cnt <= '0;
    end else begin
      wait_cnt <= stall ? wait_cnt + 1'b1 : '0;
      pend_vld <= stall;
      if (stall) {pend_instr, pend_addr, pend_wdata, pend_wstrb} <= {mem_instr, mem_addr, mem_wdata, mem_wstrb};
      if (pend_vld && (!mem_valid || {pend_instr, pend_addr, pend_wdata, pend_wstrb} != {mem_instr, mem_addr, mem_wdata, mem_wstrb}))
        proto_err <= 1'b1;
      txn_cnt <= txn_cnt + TXN_CNT_W'(done);
    end
  if (CONSISTENT != 0) begin : g_shadow
    rvfi_mem_shadow #(.TAG_W(ADDR_W - OFF_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_shadow (
      .clock      (clock),
      .resetn     (resetn),
      .tag        (mem_addr[ADDR_W-1:OFF_W]),
      .wdata      (mem_wdata),
      .wstrb      (mem_wstrb),
      .rand_rdata (rand_rdata),
      .done       (done),
      .rdata      (mem_rdata)
    );
  end else begin : g_rand
    assign mem_rdata = rand_rdata;
  end
endmodule
